// File: rtl/eight_queen_checker.sv
// Eight-queen board checker: captures N row bitmaps, verifies one-hot rows,
// then scans row pairs for column/diagonal conflicts and reports a verdict.
module eight_queen_checker #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             user_reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_bus,
  output logic             in_ready,
  output logic             busy,
  output logic             result_valid,
  output logic             solution_ok,
  output logic [1:0]       error_code,
  output logic [2:0]       fail_row_a,
  output logic [2:0]       fail_row_b,
  output logic [CNT_W-1:0] board_count,
  output logic             overflow
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_COLUMN = 2'b10;
  localparam logic [1:0] ERR_DIAG   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_CHECK   = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]     rows [N];
  logic [IDX_W-1:0] beat_idx;
  logic [IDX_W-1:0] pi, pj;
  logic [1:0]       err_code;
  logic [IDX_W-1:0] err_a, err_b;

  logic             in_onehot_c;
  logic             last_beat_c;
  logic             last_pair_c;
  logic [N-1:0]     row_i_c, row_j_c;
  logic [IDX_W-1:0] dist_c;
  logic [N-1:0]     diag_mask_c;
  logic             col_hit_c, diag_hit_c;
  logic             in_ready_d, busy_d;

  // Per-beat one-hot test and current pair conflict evaluation
  always_comb begin
    in_onehot_c = (in_bus != '0) && ((in_bus & (in_bus - N'(1))) == '0);
    last_beat_c = (state == S_CAPTURE) && in_valid && (beat_idx == IDX_W'(N - 1));
    last_pair_c = (pi == IDX_W'(N - 2)) && (pj == IDX_W'(N - 1));
    row_i_c     = rows[pi];
    row_j_c     = rows[pj];
    dist_c      = pj - pi;
    diag_mask_c = (row_i_c << dist_c) | (row_i_c >> dist_c);
    col_hit_c   = (row_i_c & row_j_c) != '0;
    diag_hit_c  = (diag_mask_c & row_j_c) != '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (user_reset) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (in_valid) state_nx = S_CAPTURE;
      S_CAPTURE: if (last_beat_c) state_nx = S_CHECK;
      S_CHECK:   if ((err_code != ERR_NONE) || col_hit_c || diag_hit_c || last_pair_c)
                   state_nx = S_REPORT;
      S_REPORT:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Flow-control outputs, registered from the upcoming state
  always_comb begin
    in_ready_d = (state_nx == S_IDLE) || (state_nx == S_CAPTURE);
    busy_d     = (state_nx != S_IDLE);
  end

  // Row capture, pair scan, verdict and counters
  always_ff @(posedge clk) begin
    if (user_reset) begin
      for (int r = 0; r < int'(N); r++) rows[r] <= '0;
      beat_idx     <= '0;
      pi           <= '0;
      pj           <= '0;
      err_code     <= ERR_NONE;
      err_a        <= '0;
      err_b        <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      solution_ok  <= 1'b0;
      error_code   <= ERR_NONE;
      fail_row_a   <= 3'd0;
      fail_row_b   <= 3'd0;
      board_count  <= '0;
      overflow     <= 1'b0;
    end else begin
      in_ready     <= in_ready_d;
      busy         <= busy_d;
      result_valid <= (state == S_REPORT);

      if (in_valid && ((state == S_CHECK) || (state == S_REPORT)))
        overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rows[0]  <= in_bus;
            beat_idx <= IDX_W'(1);
            err_a    <= '0;
            err_b    <= '0;
            err_code <= in_onehot_c ? ERR_NONE : ERR_ONEHOT;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            rows[beat_idx] <= in_bus;
            beat_idx       <= beat_idx + IDX_W'(1);
            if ((err_code == ERR_NONE) && !in_onehot_c) begin
              err_code <= ERR_ONEHOT;
              err_a    <= beat_idx;
              err_b    <= beat_idx;
            end
          end
          if (last_beat_c) begin
            pi <= '0;
            pj <= IDX_W'(1);
          end
        end
        S_CHECK: begin
          if (err_code == ERR_NONE) begin
            if (col_hit_c) begin
              err_code <= ERR_COLUMN;
              err_a    <= pi;
              err_b    <= pj;
            end else if (diag_hit_c) begin
              err_code <= ERR_DIAG;
              err_a    <= pi;
              err_b    <= pj;
            end
          end
          if (pj == IDX_W'(N - 1)) begin
            pi <= pi + IDX_W'(1);
            pj <= pi + IDX_W'(2);
          end else begin
            pj <= pj + IDX_W'(1);
          end
        end
        S_REPORT: begin
          solution_ok <= (err_code == ERR_NONE);
          error_code  <= err_code;
          fail_row_a  <= 3'(err_a);
          fail_row_b  <= 3'(err_b);
          if ((err_code == ERR_NONE) && (board_count != {CNT_W{1'b1}}))
            board_count <= board_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_queen_checker.sv
// Scoreboard bench for eight_queen_checker: directed boards, decoupled monitor.
module tb_eight_queen_checker;

  logic       clk = 1'b0;
  logic       user_reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_bus = 8'h00;
  logic       sat_en = 1'b0;
  logic       in_valid2;

  logic       in_ready, busy, result_valid, solution_ok, overflow;
  logic [1:0] error_code;
  logic [2:0] fail_row_a, fail_row_b;
  logic [6:0] board_count;

  logic       in_ready2, busy2, result_valid2, solution_ok2, overflow2;
  logic [1:0] error_code2;
  logic [2:0] fail_row_a2, fail_row_b2;
  logic [1:0] board_count2;

  assign in_valid2 = in_valid & sat_en;

  eight_queen_checker #(.N(8), .CNT_W(7)) dut (
    .clk(clk), .user_reset(user_reset), .in_valid(in_valid), .in_bus(in_bus),
    .in_ready(in_ready), .busy(busy), .result_valid(result_valid),
    .solution_ok(solution_ok), .error_code(error_code),
    .fail_row_a(fail_row_a), .fail_row_b(fail_row_b),
    .board_count(board_count), .overflow(overflow)
  );

  eight_queen_checker #(.N(8), .CNT_W(2)) dut_sat (
    .clk(clk), .user_reset(user_reset), .in_valid(in_valid2), .in_bus(in_bus),
    .in_ready(in_ready2), .busy(busy2), .result_valid(result_valid2),
    .solution_ok(solution_ok2), .error_code(error_code2),
    .fail_row_a(fail_row_a2), .fail_row_b(fail_row_b2),
    .board_count(board_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic [1:0]  code;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [6:0]  cnt;
    logic        ovf;
    int unsigned at;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cnt2_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_cnt2 = 0;
  logic        exp_ovf = 1'b0;

  localparam logic [63:0] B_VALID = 64'h08_02_40_04_20_80_10_01;
  localparam logic [63:0] B_COL   = 64'h08_02_40_04_20_01_10_01;
  localparam logic [63:0] B_DIAG  = 64'h08_10_40_04_20_80_02_01;
  localparam logic [63:0] B_NOHOT = 64'h08_02_03_04_00_80_10_01;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic vld);
    @(negedge clk);
    in_valid = vld;
    in_bus   = v;
  endtask

  // Issue one board; the expectation is queued as the last beat is driven
  task automatic send(input logic [63:0] brd, input bit gapped, input logic ok,
                      input logic [1:0] code, input logic [2:0] a, input logic [2:0] b,
                      input int unsigned lat);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      if (gapped && r > 0) drive(8'h00, 1'b0);
      drive(brd[8*r +: 8], 1'b1);
    end
    if (ok) exp_cnt++;
    e.ok = ok; e.code = code; e.a = a; e.b = b;
    e.cnt = 7'(exp_cnt); e.ovf = exp_ovf; e.at = cyc + 1 + lat;
    sb_q.push_back(e);
    if (sat_en && ok) begin
      if (exp_cnt2 < 3) exp_cnt2++;
      cnt2_q.push_back(exp_cnt2);
    end
    drive(8'h00, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || cnt2_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("result_timeout", 32'(sb_q.size() + cnt2_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_solution_ok"}, 32'(solution_ok), 32'd0);
    chk({tag, "_error_code"}, 32'(error_code), 32'd0);
    chk({tag, "_fail_row_a"}, 32'(fail_row_a), 32'd0);
    chk({tag, "_fail_row_b"}, 32'(fail_row_b), 32'd0);
    chk({tag, "_board_count"}, 32'(board_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Monitor: compare every verdict against the head of the scoreboard
  always @(negedge clk) begin
    if (!user_reset && result_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("solution_ok", 32'(solution_ok), 32'(e.ok));
        chk("error_code", 32'(error_code), 32'(e.code));
        chk("fail_row_a", 32'(fail_row_a), 32'(e.a));
        chk("fail_row_b", 32'(fail_row_b), 32'(e.b));
        chk("board_count", 32'(board_count), 32'(e.cnt));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("result_cycle", cyc, e.at);
      end
    end
    if (!user_reset && result_valid2) begin
      if (cnt2_q.size() == 0) begin
        chk("unexpected_sat_result", 32'd1, 32'd0);
      end else begin
        int unsigned c;
        c = cnt2_q.pop_front();
        chk("sat_solution_ok", 32'(solution_ok2), 32'd1);
        chk("sat_board_count", 32'(board_count2), c);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    user_reset = 1'b0;

    send(B_VALID, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 29);
    wait_done();
    send(B_COL,   1'b0, 1'b0, 2'b10, 3'd0, 3'd2, 3);
    wait_done();
    send(B_DIAG,  1'b0, 1'b0, 2'b11, 3'd0, 3'd1, 2);
    wait_done();
    send(B_NOHOT, 1'b0, 1'b0, 2'b01, 3'd3, 3'd3, 2);
    wait_done();

    // Reset in the middle of capture
    for (int r = 0; r < 4; r++) drive(B_VALID[8*r +: 8], 1'b1);
    @(negedge clk);
    in_valid   = 1'b0;
    user_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    user_reset = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;

    send(B_VALID, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 29);
    wait_done();
    send(B_VALID, 1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 29);
    wait_done();
    send(B_DIAG,  1'b1, 1'b0, 2'b11, 3'd0, 3'd1, 2);
    wait_done();

    // Stray beat during CHECK: sticky overflow, verdict unchanged
    exp_ovf = 1'b1;
    send(B_VALID, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 29);
    drive(8'h01, 1'b1);
    drive(8'h00, 1'b0);
    wait_done();

    // Saturating counter on the narrow instance: 1,2,3,3,3
    sat_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(B_VALID, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 29);
      wait_done();
    end
    sat_en = 1'b0;
    chk("final_board_count", 32'(board_count), exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eight_queen_checker.md
Name: eight_queen_checker

Overview:
- Consumer-side counterpart of the eight-queen solver: receives a solved board as 8 row bytes on the solver's output bus and independently verifies it is a legal placement.
- Sits beside the solver in the system/bench, sampling `out_bus` while the solver's `done` is high.
- Reports pass/fail with a failure code and the offending row pair, and keeps a running count of verified solutions.

Parameters:
- N, 8, board size; rows per board and bits per row. Only 8 is supported in silicon; 4 is supported for bench use.
- CNT_W, 7, width of the solution counter. It saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- user_reset  in  1  synchronous, active-high reset
- in_valid  in  1  row beat valid; driven by the solver's `done`
- in_bus  in  N  row bitmap, one-hot column of the queen, row 0 first; driven by `out_bus`
- in_ready  out  1  high in IDLE and CAPTURE
- busy  out  1  high in CAPTURE, CHECK and REPORT
- result_valid  out  1  one-cycle pulse when the verdict is available
- solution_ok  out  1  verdict; held until the next result_valid
- error_code  out  2  00 ok, 01 row not one-hot, 10 column conflict, 11 diagonal conflict; held
- fail_row_a  out  3  first offending row (lower index); held
- fail_row_b  out  3  second offending row, equal to fail_row_a for code 01; held
- board_count  out  CNT_W  number of boards with solution_ok=1 since reset
- overflow  out  1  sticky; set when a beat arrives while in_ready=0

Behaviour:
- Reset: user_reset has priority over all other activity, including mid-CAPTURE and mid-CHECK. It forces:
  - state to IDLE and all row registers to 0;
  - in_ready=1, busy=0, result_valid=0, solution_ok=0, error_code=00;
  - fail_row_a=fail_row_b=0, board_count=0, overflow=0.
- State machine: IDLE -> CAPTURE -> CHECK -> REPORT -> IDLE.
- IDLE: an in_valid beat stores row 0, sets beat index to 1 and moves to CAPTURE.
- CAPTURE:
  - Each in_valid beat stores row[index] and increments the index.
  - Cycles with in_valid=0 hold state; there is no timeout.
  - The beat storing row N-1 moves to CHECK on the next edge.
- One-hot check, done per beat during capture:
  - A row with popcount != 1 (including 0x00) records error_code=01 with fail_row_a=fail_row_b=that row.
  - Only the first such row is recorded; capture still completes all N beats.
- CHECK:
  - If a one-hot error is already recorded, CHECK lasts exactly 1 cycle and goes to REPORT.
  - Otherwise it evaluates one pair (i,j), i<j, per cycle in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1). That is 28 pairs for N=8.
  - Column conflict: (row_i & row_j) != 0, giving code 10.
  - Diagonal conflict: ((row_i << d) | (row_i >> d)) & row_j != 0, with d=j-i and shifts truncated to N bits (no wrap), giving code 11.
  - Column takes precedence over diagonal within the same pair.
  - The first failing pair latches the code and i/j, and goes to REPORT the next cycle (early exit).
  - If all pairs pass, go to REPORT after pair (N-2,N-1).
- REPORT (1 cycle):
  - result_valid=1, solution_ok=(error_code==00).
  - board_count increments on pass, saturating.
  - Return to IDLE.
- Latency on a full pass, from the edge capturing the last beat to result_valid: 29 cycles for N=8 (28 CHECK cycles plus 1). On a one-hot failure it is 2 cycles.
- Beats during CHECK/REPORT are dropped and set overflow. They are never stored into the next board.
- A beat in the same cycle the FSM returns to IDLE is accepted, because in_ready is already 1 in IDLE.
- Outputs are registered; no combinational path from in_* to any output.

Test Plan:
- Valid solution: beats 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 (no gaps) -> result_valid exactly 29 cycles after the last beat, solution_ok=1, error_code=00, board_count=1.
- Column conflict: 0x01,0x10,0x01,0x20,0x04,0x40,0x02,0x08 -> solution_ok=0, code=10, fail_row_a=0, fail_row_b=2, result 3 cycles after the last beat, board_count unchanged.
- Diagonal conflict: 0x01,0x02,0x80,0x20,0x04,0x40,0x10,0x08 -> code=11, fail_row_a=0, fail_row_b=1, result 2 cycles after the last beat.
- Not one-hot: row 3 = 0x00, then row 5 = 0x03 -> code=01, fail_row_a=fail_row_b=3, result_valid 2 cycles after the 8th beat.
- Reset and flow control:
  - Assert user_reset after 4 beats -> all outputs at reset values next edge; a fresh 8-beat valid board then passes.
  - Gapped beats (in_valid toggling) give the same result as back-to-back beats.
  - A beat during CHECK sets overflow=1 and does not alter the verdict.
- Counter saturation: with CNT_W=2, feed 5 valid boards -> board_count sequence 1,2,3,3,3.
